// File: rtl/vote_session_ctrl_pkg.sv
// Shared types and defaults for the vote session controller.
package vote_session_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    TALLY  = 2'd2,
    RESULT = 2'd3
  } vote_state_e;

  localparam int DEF_N_VOTERS = 4;
  localparam int DEF_TIMEOUT  = 16;
  localparam int DEF_CNT_W    = 3;

endpackage

// File: rtl/vote_session_ctrl_tally.sv
// Combinational tally of a closed ballot: counts yes/no among voters who voted.
module vote_tally
  import vote_session_ctrl_pkg::*;
#(
  parameter int N_VOTERS = DEF_N_VOTERS,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic [N_VOTERS-1:0] ballot,
  input  logic [N_VOTERS-1:0] voted,
  output logic [CNT_W-1:0]    yes_count,
  output logic [CNT_W-1:0]    no_count,
  output logic                pass,
  output logic                tie
);

  function automatic logic [CNT_W-1:0] popcnt(input logic [N_VOTERS-1:0] v);
    logic [CNT_W-1:0] c;
    c = {CNT_W{1'b0}};
    for (int i = 0; i < N_VOTERS; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // Count cast yes and no votes; abstainers fall in neither bucket.
  always_comb begin
    yes_count = popcnt(ballot & voted);
    no_count  = popcnt(~ballot & voted);
    pass      = (yes_count > no_count);
    tie       = (yes_count == no_count);
  end

endmodule

// File: rtl/vote_session_ctrl.sv
// Ballot sequencer: opens on start, accepts one vote per voter, closes on full
// turnout or timeout, tallies, and holds the result until acknowledged.
module vote_session_ctrl
  import vote_session_ctrl_pkg::*;
#(
  parameter int N_VOTERS = DEF_N_VOTERS,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N_VOTERS-1:0] vote_req,
  input  logic [N_VOTERS-1:0] vote_yes,
  output logic [N_VOTERS-1:0] vote_ack,
  output logic [N_VOTERS-1:0] voted,
  output logic                busy,
  output logic                result_valid,
  output logic                result_pass,
  output logic                result_tie,
  output logic [CNT_W-1:0]    yes_count,
  output logic [CNT_W-1:0]    no_count,
  output logic                timed_out,
  input  logic                result_ack
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  vote_state_e         state_r, state_next_s;
  logic [N_VOTERS-1:0] ballot_r, voted_r, ack_r;
  logic [TMR_W-1:0]    timer_r;
  logic                busy_r, rv_r, pass_r, tie_r, to_r;
  logic [CNT_W-1:0]    yes_r, no_r;
  logic [N_VOTERS-1:0] accept_s;
  logic                all_voted_s, timer_exp_s;
  logic [CNT_W-1:0]    t_yes_s, t_no_s;
  logic                t_pass_s, t_tie_s;

  vote_tally #(.N_VOTERS(N_VOTERS), .CNT_W(CNT_W)) u_tally (
    .ballot    (ballot_r),
    .voted     (voted_r),
    .yes_count (t_yes_s),
    .no_count  (t_no_s),
    .pass      (t_pass_s),
    .tie       (t_tie_s)
  );

  // Accept mask and close conditions; the exit check sees this cycle's accepts.
  always_comb begin
    accept_s    = {N_VOTERS{1'b0}};
    if (state_r == OPEN) begin
      accept_s = vote_req & ~voted_r;
    end else begin
      accept_s = {N_VOTERS{1'b0}};
    end
    all_voted_s = &(voted_r | accept_s);
    timer_exp_s = (timer_r == TMR_LAST);
  end

  // Next-state decode for the session FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = OPEN;
        else       state_next_s = IDLE;
      end
      OPEN: begin
        if (all_voted_s || timer_exp_s) state_next_s = TALLY;
        else                            state_next_s = OPEN;
      end
      TALLY: state_next_s = RESULT;
      RESULT: begin
        if (result_ack) state_next_s = IDLE;
        else            state_next_s = RESULT;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register plus busy flag and one-cycle ack pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      ack_r   <= {N_VOTERS{1'b0}};
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != IDLE);
      ack_r   <= accept_s;
    end
  end

  // Session datapath: ballot capture, timer, and registered tally result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ballot_r <= {N_VOTERS{1'b0}};
      voted_r  <= {N_VOTERS{1'b0}};
      timer_r  <= {TMR_W{1'b0}};
      to_r     <= 1'b0;
      rv_r     <= 1'b0;
      pass_r   <= 1'b0;
      tie_r    <= 1'b0;
      yes_r    <= {CNT_W{1'b0}};
      no_r     <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            ballot_r <= {N_VOTERS{1'b0}};
            voted_r  <= {N_VOTERS{1'b0}};
            timer_r  <= {TMR_W{1'b0}};
            to_r     <= 1'b0;
          end
        end
        OPEN: begin
          voted_r  <= voted_r | accept_s;
          ballot_r <= (ballot_r & ~accept_s) | (vote_yes & accept_s);
          timer_r  <= timer_r + TMR_W'(1);
          if (!all_voted_s && timer_exp_s) to_r <= 1'b1;
        end
        TALLY: begin
          yes_r  <= t_yes_s;
          no_r   <= t_no_s;
          pass_r <= t_pass_s;
          tie_r  <= t_tie_s;
          rv_r   <= 1'b1;
        end
        RESULT: begin
          if (result_ack) rv_r <= 1'b0;
        end
        default: rv_r <= 1'b0;
      endcase
    end
  end

  assign vote_ack     = ack_r;
  assign voted        = voted_r;
  assign busy         = busy_r;
  assign result_valid = rv_r;
  assign result_pass  = pass_r;
  assign result_tie   = tie_r;
  assign yes_count    = yes_r;
  assign no_count     = no_r;
  assign timed_out    = to_r;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Scoreboard bench for vote_session_ctrl: stimulus pushes expected acks and
// results, a negedge monitor pops and compares when the DUT presents them.
module tb_vote_session_ctrl;

  typedef struct packed {
    logic [3:0]  mask;
    logic [31:0] cyc;
  } ack_exp_t;

  typedef struct packed {
    logic [3:0]  voted;
    logic [2:0]  yes;
    logic [2:0]  no;
    logic        pass;
    logic        tie;
    logic        to;
    logic [31:0] cyc;
  } res_exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] vote_req = 4'd0;
  logic [3:0] vote_yes = 4'd0;
  logic       result_ack = 1'b0;
  logic [3:0] vote_ack, voted;
  logic       busy, result_valid, result_pass, result_tie, timed_out;
  logic [2:0] yes_count, no_count;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] cyc = 32'd0;
  logic rv_prev = 1'b0;
  ack_exp_t ack_q[$];
  res_exp_t res_q[$];

  vote_session_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vote_req(vote_req),
    .vote_yes(vote_yes), .vote_ack(vote_ack), .voted(voted), .busy(busy),
    .result_valid(result_valid), .result_pass(result_pass),
    .result_tie(result_tie), .yes_count(yes_count), .no_count(no_count),
    .timed_out(timed_out), .result_ack(result_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pop expectations whenever an ack pulse or a new result appears.
  always @(negedge clk) begin
    if (vote_ack != 4'd0) begin
      if (ack_q.size() == 0) begin
        chk("unexpected_ack", {60'd0, vote_ack}, 64'd0);
      end else begin
        ack_exp_t e;
        e = ack_q.pop_front();
        chk("ack_mask", {60'd0, vote_ack}, {60'd0, e.mask});
        chk("ack_cycle", {32'd0, cyc}, {32'd0, e.cyc});
      end
    end
    if (result_valid && !rv_prev) begin
      if (res_q.size() == 0) begin
        chk("unexpected_result", 64'd1, 64'd0);
      end else begin
        res_exp_t r;
        r = res_q.pop_front();
        chk("result_fields",
            {51'd0, voted, yes_count, no_count, result_pass, result_tie, timed_out},
            {51'd0, r.voted, r.yes, r.no, r.pass, r.tie, r.to});
        chk("result_cycle", {32'd0, cyc}, {32'd0, r.cyc});
      end
    end
    rv_prev <= result_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic open_session(output logic [31:0] e);
    start = 1'b1;
    tick();
    start = 1'b0;
    e = cyc;
  endtask

  task automatic do_vote(input logic [3:0] req, input logic [3:0] yes, input logic [3:0] exp_ack);
    ack_exp_t a;
    vote_req = req;
    vote_yes = yes;
    if (exp_ack != 4'd0) begin
      a.mask = exp_ack;
      a.cyc  = cyc + 32'd1;
      ack_q.push_back(a);
    end
    tick();
    vote_req = 4'd0;
    vote_yes = 4'd0;
  endtask

  task automatic push_res(input logic [3:0] v, input logic [2:0] y, input logic [2:0] n,
                          input logic p, input logic t, input logic to, input logic [31:0] c);
    res_exp_t r;
    r.voted = v; r.yes = y; r.no = n; r.pass = p; r.tie = t; r.to = to; r.cyc = c;
    res_q.push_back(r);
  endtask

  task automatic wait_rv();
    int k;
    k = 0;
    while (!result_valid && k < 40) begin
      tick();
      k++;
    end
    if (!result_valid) chk("result_timeout", 64'd0, 64'd1);
    #6;
  endtask

  task automatic ack_result();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    chk("idle_busy", {63'd0, busy}, 64'd0);
    chk("idle_rv", {63'd0, result_valid}, 64'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {46'd0, vote_ack, voted, busy, result_valid, result_pass, result_tie,
               yes_count, no_count, timed_out}, 64'd0);
  endtask

  initial begin
    logic [31:0] e;
    #22;
    chk_all_zero("reset_state");
    rst_n = 1'b1;
    tick();
    chk("idle_busy_after_reset", {63'd0, busy}, 64'd0);

    // Vote in IDLE is ignored (monitor flags any ack).
    do_vote(4'b1111, 4'b1111, 4'b0000);
    tick();

    // Unanimous yes.
    open_session(e);
    chk("open_busy", {63'd0, busy}, 64'd1);
    push_res(4'b1111, 3'd4, 3'd0, 1'b1, 1'b0, 1'b0, e + 32'd2);
    do_vote(4'b1111, 4'b1111, 4'b1111);
    wait_rv();
    ack_result();

    // Split tie across separate cycles.
    open_session(e);
    push_res(4'b1111, 3'd2, 3'd2, 1'b0, 1'b1, 1'b0, e + 32'd5);
    do_vote(4'b0001, 4'b0001, 4'b0001);
    do_vote(4'b0010, 4'b0000, 4'b0010);
    do_vote(4'b0100, 4'b0100, 4'b0100);
    do_vote(4'b1000, 4'b0000, 4'b1000);
    wait_rv();
    ack_result();

    // Timeout with only voter2 voting yes.
    open_session(e);
    push_res(4'b0100, 3'd1, 3'd0, 1'b1, 1'b0, 1'b1, e + 32'd17);
    do_vote(4'b0100, 4'b0100, 4'b0100);
    wait_rv();
    ack_result();

    // Duplicate votes from voter1 are ignored.
    open_session(e);
    push_res(4'b1111, 3'd3, 3'd1, 1'b1, 1'b0, 1'b0, e + 32'd5);
    do_vote(4'b0010, 4'b0000, 4'b0010);
    do_vote(4'b0010, 4'b0010, 4'b0000);
    do_vote(4'b0010, 4'b0010, 4'b0000);
    do_vote(4'b1101, 4'b1101, 4'b1101);
    wait_rv();
    ack_result();

    // Start pulsed in OPEN and in RESULT; result held without ack.
    open_session(e);
    push_res(4'b1111, 3'd1, 3'd3, 1'b0, 1'b0, 1'b0, e + 32'd3);
    start = 1'b1;
    do_vote(4'b0001, 4'b0001, 4'b0001);
    start = 1'b0;
    do_vote(4'b1110, 4'b0000, 4'b1110);
    wait_rv();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_fields", {50'd0, result_valid, busy, voted, yes_count, no_count,
                          result_pass, result_tie, timed_out},
          {50'd0, 1'b1, 1'b1, 4'b1111, 3'd1, 3'd3, 1'b0, 1'b0, 1'b0});
      tick();
    end
    ack_result();
    tick();
    chk("idle_keeps_result", {52'd0, busy, voted, yes_count, no_count, result_valid},
        {52'd0, 1'b0, 4'b1111, 3'd1, 3'd3, 1'b0});

    // Reset in the middle of OPEN.
    open_session(e);
    do_vote(4'b0001, 4'b0001, 4'b0001);
    do_vote(4'b0010, 4'b0000, 4'b0010);
    #6;
    rst_n = 1'b0;
    #2;
    chk_all_zero("mid_reset_zero");
    rst_n = 1'b1;
    tick();
    chk_all_zero("post_reset_idle");
    open_session(e);
    chk("new_session_voted", {60'd0, voted}, 64'd0);
    push_res(4'b1111, 3'd1, 3'd3, 1'b0, 1'b0, 1'b0, e + 32'd3);
    do_vote(4'b1100, 4'b0100, 4'b1100);
    do_vote(4'b0011, 4'b0000, 4'b0011);
    wait_rv();
    ack_result();
    tick();
    tick();

    chk("ack_queue_drained", {32'd0, 32'(ack_q.size())}, 64'd0);
    chk("res_queue_drained", {32'd0, 32'(res_q.size())}, 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
